// File: rtl/obi_timer_sbr.sv
// OBI subordinate timer: prescaled 32-bit up-counter with compare match, auto-reload and
// level interrupt, behind a 4-register window with an in-order response FIFO.
module obi_timer_sbr #(
  parameter int unsigned RspDepth      = 2,
  parameter int unsigned PrescaleWidth = 16,
  parameter logic [31:0] CompareRst    = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [72:0] obi_req_i,
  output logic [36:0] obi_rsp_o,
  output logic        irq_o
);

  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntW = $clog2(RspDepth + 1);

  // Request fields: {addr, we, be, wdata, aid, a_optional, req, rready}
  logic [31:0] a_addr;
  logic        a_we;
  logic [3:0]  a_be;
  logic [31:0] a_wdata;
  logic        a_aid;
  logic        a_req;
  logic        a_rready;
  logic        unused_bits;

  assign a_addr      = obi_req_i[72:41];
  assign a_we        = obi_req_i[40];
  assign a_be        = obi_req_i[39:36];
  assign a_wdata     = obi_req_i[35:4];
  assign a_aid       = obi_req_i[3];
  assign a_req       = obi_req_i[1];
  assign a_rready    = obi_req_i[0];
  assign unused_bits = ^{obi_req_i[72:45], obi_req_i[2]};

  logic                     en_reg, auto_reg, irq_en_reg, match_reg;
  logic [PrescaleWidth-1:0] prescale_reg, pc_reg;
  logic [31:0]              compare_reg, count_reg;

  logic                     en_next, auto_next, irq_en_next, match_next;
  logic [PrescaleWidth-1:0] prescale_next, pc_next;
  logic [31:0]              compare_next, count_next;

  logic [CntW-1:0] fifo_cnt_reg, fifo_cnt_next;
  logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [33:0]     fifo_mem [RspDepth];

  logic        gnt, accept, aligned, push, pop, rvalid;
  logic        wr_any, wr_ctrl, wr_prescale, wr_compare, wr_count;
  logic        tick, hit, w1c;
  logic [31:0] wmask, rd_val, rsp_rdata, pre_merged;
  logic [33:0] head;

  assign gnt     = !rst_i && (fifo_cnt_reg < CntW'(RspDepth));
  assign accept  = a_req && gnt;
  assign aligned = (a_addr[1:0] == 2'b00);
  assign push    = accept;
  assign rvalid  = (fifo_cnt_reg != '0);
  assign pop     = rvalid && a_rready;

  // A write with no byte enables is accepted but must not disturb any state.
  assign wr_any      = accept && a_we && aligned && (|a_be);
  assign wr_ctrl     = wr_any && (a_addr[3:2] == 2'd0);
  assign wr_prescale = wr_any && (a_addr[3:2] == 2'd1);
  assign wr_compare  = wr_any && (a_addr[3:2] == 2'd2);
  assign wr_count    = wr_any && (a_addr[3:2] == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign wmask[gi*8 +: 8] = {8{a_be[gi]}};
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    case (a_addr[3:2])
      2'd0: rd_val = {23'd0, match_reg, 5'd0, irq_en_reg, auto_reg, en_reg};
      2'd1: rd_val = 32'(prescale_reg);
      2'd2: rd_val = compare_reg;
      2'd3: rd_val = count_reg;
      default: rd_val = '0;
    endcase
  end

  assign rsp_rdata  = (aligned && !a_we) ? rd_val : 32'd0;
  assign pre_merged = (32'(prescale_reg) & ~wmask) | (a_wdata & wmask);

  assign tick = en_reg && (pc_reg == prescale_reg);
  assign hit  = tick && (count_reg == compare_reg);
  assign w1c  = wr_ctrl && a_be[1] && a_wdata[8];

  always_comb begin
    en_next       = en_reg;
    auto_next     = auto_reg;
    irq_en_next   = irq_en_reg;
    prescale_next = prescale_reg;
    compare_next  = compare_reg;
    pc_next       = pc_reg;
    count_next    = count_reg;
    // A match being set outranks a simultaneous write-1-to-clear.
    match_next    = hit || (match_reg && !w1c);

    if (wr_ctrl && a_be[0]) begin
      en_next     = a_wdata[0];
      auto_next   = a_wdata[1];
      irq_en_next = a_wdata[2];
    end
    if (wr_prescale) prescale_next = pre_merged[PrescaleWidth-1:0];
    if (wr_compare)  compare_next  = (compare_reg & ~wmask) | (a_wdata & wmask);

    if (wr_prescale || tick) pc_next = '0;
    else if (en_reg)         pc_next = pc_reg + 1'b1;

    if (wr_count)  count_next = (count_reg & ~wmask) | (a_wdata & wmask);
    else if (tick) count_next = (hit && auto_reg) ? 32'd0 : count_reg + 32'd1;
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_reg       <= 1'b0;
      auto_reg     <= 1'b0;
      irq_en_reg   <= 1'b0;
      match_reg    <= 1'b0;
      prescale_reg <= '0;
      pc_reg       <= '0;
      compare_reg  <= CompareRst;
      count_reg    <= '0;
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      en_reg       <= en_next;
      auto_reg     <= auto_next;
      irq_en_reg   <= irq_en_next;
      match_reg    <= match_next;
      prescale_reg <= prescale_next;
      pc_reg       <= pc_next;
      compare_reg  <= compare_next;
      count_reg    <= count_next;
      fifo_cnt_reg <= fifo_cnt_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

  // Entry = {rdata, rid, err}; storage needs no reset since rvalid masks it.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= {rsp_rdata, a_aid, !aligned};
  end

  assign head      = rvalid ? fifo_mem[rd_ptr_reg] : 34'd0;
  assign obi_rsp_o = {head, 1'b0, gnt, rvalid};
  assign irq_o     = match_reg && irq_en_reg;

endmodule

// File: tb/tb_obi_timer_sbr.sv
// Self-checking bench for obi_timer_sbr: driver with a behavioural timer model feeding a
// response scoreboard, and an independent monitor that checks responses as they are popped.
module tb_obi_timer_sbr;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [72:0] obi_req_i;
  logic [36:0] obi_rsp_o;
  logic        irq_o;

  obi_timer_sbr #(.RspDepth(2), .PrescaleWidth(16), .CompareRst(32'hFFFF_FFFF)) dut (
    .clk_i(clk), .rst_i(rst_i), .obi_req_i(obi_req_i), .obi_rsp_o(obi_rsp_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Driven request fields
  logic        d_req = 0, d_we = 0, d_aid = 0, d_rready = 1;
  logic [31:0] d_addr = 0, d_wdata = 0;
  logic [3:0]  d_be = 0;

  // Reference model state
  logic        m_en, m_auto, m_irqen, m_match;
  logic [15:0] m_pre, m_pc;
  logic [31:0] m_cmp, m_count;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_irqen = 0; m_match = 0;
    m_pre = 0; m_pc = 0; m_cmp = 32'hFFFF_FFFF; m_count = 0; m_cnt = 0;
    sb.delete();
  endtask

  // Advance the model by one clock given whether the current request is accepted.
  task automatic model_update(input bit acc);
    rsp_t        r;
    logic [31:0] regs[4];
    logic [31:0] merged;
    bit          tick, set_match, clr_match, wr;
    int          sel;
    regs[0] = {23'd0, m_match, 5'd0, m_irqen, m_auto, m_en};
    regs[1] = {16'd0, m_pre};
    regs[2] = m_cmp;
    regs[3] = m_count;
    sel  = int'(d_addr[3:2]);
    tick = m_en && (m_pc == m_pre);
    set_match = tick && (m_count == m_cmp);
    clr_match = 0;
    wr = acc && d_we && (d_addr[1:0] == 0) && (d_be != 0);
    if (acc) begin
      r.rid = d_aid;
      r.err = (d_addr[1:0] != 0);
      r.rdata = (!r.err && !d_we) ? regs[sel] : 32'd0;
      sb.push_back(r);
    end
    if (m_en) m_pc = tick ? 16'd0 : m_pc + 16'd1;
    if (tick) m_count = (set_match && m_auto) ? 32'd0 : m_count + 32'd1;
    if (wr) begin
      merged = merge(regs[sel], d_wdata, d_be);
      case (sel)
        0: begin
          if (d_be[0]) begin m_en = d_wdata[0]; m_auto = d_wdata[1]; m_irqen = d_wdata[2]; end
          clr_match = d_be[1] && d_wdata[8];
        end
        1: begin m_pre = merged[15:0]; m_pc = 0; end
        2: m_cmp = merged;
        default: m_count = merged;
      endcase
    end
    if (clr_match) m_match = 0;
    if (set_match) m_match = 1;
  endtask

  // One clock: drive inputs, check flop-derived outputs, advance the model.
  task automatic step();
    bit acc, pop, m_gnt;
    obi_req_i = {d_addr, d_we, d_be, d_wdata, d_aid, 1'b0, d_req, d_rready};
    #1;
    if (rst_i) model_reset();
    m_gnt = !rst_i && (m_cnt < 2);
    chk("gnt", 32'(obi_rsp_o[1]), 32'(m_gnt));
    chk("rvalid", 32'(obi_rsp_o[0]), 32'(m_cnt > 0));
    chk("irq", 32'(irq_o), 32'(m_match && m_irqen));
    acc = d_req && m_gnt;
    pop = (m_cnt > 0) && d_rready && !rst_i;
    if (!rst_i) model_update(acc);
    m_cnt = m_cnt + int'(acc) - int'(pop);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    d_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic aid);
    bit done = 0;
    d_req = 1; d_we = we; d_addr = addr; d_be = be; d_wdata = wdata; d_aid = aid;
    for (int i = 0; i < 100 && !done; i++) begin
      done = !rst_i && (m_cnt < 2);
      step();
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL bus_timeout: addr %h not granted within 100 cycles", addr);
    end
    d_req = 0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(1, addr, 4'hF, data, 0);
  endtask

  task automatic rd(input logic [31:0] addr);
    bus(0, addr, 4'h0, 32'd0, 1);
  endtask

  // Monitor: a pop happens at the next rising edge whenever rvalid & rready here.
  always @(negedge clk) begin
    if (!rst_i && obi_rsp_o[0]) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_rsp: rdata %h with no outstanding request", obi_rsp_o[36:5]);
      end else if (obi_req_i[0]) begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", obi_rsp_o[36:5], e.rdata);
        chk("rsp_rid", 32'(obi_rsp_o[4]), 32'(e.rid));
        chk("rsp_err", 32'(obi_rsp_o[3]), 32'(e.err));
        chk("rsp_ropt", 32'(obi_rsp_o[2]), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] rnd;
    rst_i = 1;
    obi_req_i = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset held during traffic: no grant, no response, no interrupt
    d_req = 1; d_addr = 32'h8; d_we = 0;
    for (int i = 0; i < 3; i++) step();
    d_req = 0;
    rst_i = 0;
    idle(1);
    rd(32'h8);
    idle(2);

    // Write/read COUNT with aid=1
    bus(1, 32'hC, 4'hF, 32'h1234_5678, 1);
    rd(32'hC);
    idle(2);

    // Prescaled counting, match with auto-reload, interrupt
    wr(32'hC, 0);
    wr(32'h4, 3);
    wr(32'h8, 2);
    wr(32'h0, 7);
    for (int i = 0; i < 16; i++) begin rd(32'hC); end
    rd(32'h0);
    idle(2);

    // Reset with queued responses and irq asserted
    d_rready = 0;
    rd(32'hC);
    rd(32'h0);
    idle(1);
    rst_i = 1;
    idle(2);
    rst_i = 0;
    d_rready = 1;
    idle(2);

    // Backpressure: two outstanding, third held until the first pop
    d_rready = 0;
    rd(32'h8);
    wr(32'hC, 32'hCAFE_0001);
    d_req = 1; d_we = 0; d_addr = 32'h4; d_be = 0; d_aid = 1;
    for (int i = 0; i < 3; i++) step();
    d_rready = 1;
    rd(32'h4);
    idle(3);

    // Misaligned read and be=0 write
    bus(0, 32'h2, 4'hF, 0, 1);
    bus(1, 32'h4, 4'h0, 32'h55, 0);
    rd(32'h4);
    bus(1, 32'h9, 4'hF, 32'h77, 0);
    rd(32'h8);
    idle(2);

    // Wrap at 0xFFFF_FFFF, match on next tick, W1C in the set cycle loses
    wr(32'h0, 32'h100);
    wr(32'h4, 0);
    wr(32'h8, 0);
    wr(32'hC, 32'hFFFF_FFFF);
    wr(32'h0, 1);
    for (int i = 0; i < 20; i++) begin
      if (m_en && m_pc == m_pre && m_count == m_cmp) begin
        bus(1, 32'h0, 4'b0011, 32'h101, 0);
        break;
      end
      idle(1);
    end
    rd(32'h0);
    rd(32'hC);
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rnd = $urandom();
      d_req    = rnd[0];
      d_we     = rnd[1];
      d_rready = (rnd[4:2] != 0);
      d_aid    = rnd[5];
      d_addr   = {24'd0, 2'd0, rnd[7:6], (rnd[10:8] == 0) ? rnd[12:11] : 2'b00};
      d_be     = rnd[16:13];
      d_wdata  = $urandom();
      if (rnd[7:6] == 2'd1 && rnd[17]) d_wdata = 32'($urandom_range(0, 3));
      if (rnd[7:6] == 2'd2 && rnd[18]) d_wdata = 32'($urandom_range(0, 40));
      step();
    end

    // Drain
    d_req = 0;
    d_rready = 1;
    for (int i = 0; i < 20 && m_cnt > 0; i++) step();
    idle(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
